// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and opcode helpers for the sequential ALU.
// Opcode values match the existing 5-bit datapath ALU encoding.
package alu_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_ADDI = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_MUL  = 5'd6;
  localparam logic [4:0] OP_DIV  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_ANDI = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_ORI  = 5'd11;
  localparam logic [4:0] OP_SHL  = 5'd12;
  localparam logic [4:0] OP_SHR  = 5'd13;
  localparam logic [4:0] OP_SHRA = 5'd14;
  localparam logic [4:0] OP_ROL  = 5'd15;
  localparam logic [4:0] OP_ROR  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_NEG  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_multi(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 unsigned engine: shift-add multiply or restoring divide,
// one step per clock, WIDTH steps after start.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               op_div,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem
);

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  // p holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_next;
  logic [WIDTH-1:0]   b_q;
  logic               div_q;
  logic               run;
  logic [SHW-1:0]     cnt;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;

  assign done = run && (cnt == LAST);
  assign prod = p;
  assign quot = p[WIDTH-1:0];
  assign rem  = p[2*WIDTH-1:WIDTH];

  always_comb begin
    msum    = {1'b0, p[2*WIDTH-1:WIDTH]}
            + (p[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    shifted = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
    p_next  = {msum, p[WIDTH-1:1]};
    if (div_q) begin
      if (trial[WIDTH])
        p_next = {shifted[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
      else
        p_next = {trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      p     <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      run   <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      p     <= {{WIDTH{1'b0}}, mag_a};
      b_q   <= mag_b;
      div_q <= op_div;
      run   <= 1'b1;
      cnt   <= '0;
    end else if (run) begin
      p   <= p_next;
      cnt <= cnt + SHW'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_n.sv
// Handshaked WIDTH-bit ALU: single-cycle ops plus iterative signed
// MUL/DIV with HI/LO registers.
module alu_seq_n
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         ctrl,
  input  logic               inc_pc,
  input  logic               branch,
  input  logic [WIDTH-1:0]   reg_a,
  input  logic [WIDTH-1:0]   reg_b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] reg_c,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               div_zero,
  output logic               op_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t state_q, state_d;

  logic               accept, multi, dz, start, done;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;
  logic               neg_q, neg_r, is_div;
  logic [WIDTH-1:0]   res;
  logic               keep, err;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] rot2, rotl, rotr;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign multi    = !inc_pc && is_multi(ctrl);
  assign dz       = multi && (ctrl == OP_DIV) && (reg_b == '0);
  assign start    = accept && multi && !dz;

  assign a_neg = reg_a[WIDTH-1];
  assign b_neg = reg_b[WIDTH-1];
  assign mag_a = a_neg ? -reg_a : reg_a;
  assign mag_b = b_neg ? -reg_b : reg_b;

  alu_muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .op_div (ctrl == OP_DIV),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .done   (done),
    .prod   (prod),
    .quot   (quot),
    .rem    (rem)
  );

  assign prod_s = neg_q ? -prod : prod;
  assign quot_s = neg_q ? -quot : quot;
  assign rem_s  = neg_r ? -rem : rem;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (done) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res  = '0;
    keep = 1'b0;
    err  = 1'b0;
    sh   = reg_b[SHW-1:0];
    rot2 = {reg_a, reg_a};
    rotl = rot2 << sh;
    rotr = rot2 >> sh;
    if (inc_pc) begin
      res = reg_b + ONE;
    end else begin
      case (ctrl)
        OP_LD, OP_LDI, OP_ST,
        OP_ADD, OP_ADDI: res = reg_a + reg_b;
        OP_SUB:          res = reg_a - reg_b;
        OP_AND, OP_ANDI: res = reg_a & reg_b;
        OP_OR, OP_ORI:   res = reg_a | reg_b;
        OP_NOT:          res = ~reg_b;
        OP_NEG:          res = -reg_b;
        OP_SHL:          res = reg_a << sh;
        OP_SHR:          res = reg_a >> sh;
        OP_SHRA:         res = WIDTH'($signed(reg_a) >>> sh);
        OP_ROL:          res = rotl[2*WIDTH-1:WIDTH];
        OP_ROR:          res = rotr[WIDTH-1:0];
        OP_BR:           res = branch ? reg_a + reg_b : reg_a;
        OP_MFHI:         res = hi;
        OP_MFLO:         res = lo;
        OP_NOP, OP_HALT, OP_IN, OP_OUT,
        OP_JR, OP_JAL,
        OP_MUL, OP_DIV:  keep = 1'b1;
        default:         err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      reg_c     <= '0;
      hi        <= '0;
      lo        <= '0;
      out_valid <= 1'b0;
      div_zero  <= 1'b0;
      op_err    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      is_div    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;
      if (accept) begin
        div_zero <= 1'b0;
        op_err   <= 1'b0;
        if (dz) begin
          hi        <= reg_a;
          lo        <= '1;
          reg_c     <= {reg_a, {WIDTH{1'b1}}};
          div_zero  <= 1'b1;
          out_valid <= 1'b1;
        end else if (start) begin
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          is_div <= (ctrl == OP_DIV);
        end else begin
          out_valid <= 1'b1;
          op_err    <= err;
          if (!keep) reg_c <= {{WIDTH{1'b0}}, res};
        end
      end
      if (state_q == FIX) begin
        out_valid <= 1'b1;
        if (is_div) begin
          hi    <= rem_s;
          lo    <= quot_s;
          reg_c <= {rem_s, quot_s};
        end else begin
          {hi, lo} <= prod_s;
          reg_c    <= prod_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_n.sv
// Directed bench for alu_seq_n (WIDTH=32) with a queue-based
// reference model checked on every negedge.
module tb_alu_seq_n;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    ctrl = '0;
  logic          inc_pc = 1'b0;
  logic          branch = 1'b0;
  logic [W-1:0]  reg_a = '0;
  logic [W-1:0]  reg_b = '0;
  logic          out_valid;
  logic [2*W-1:0] reg_c;
  logic [W-1:0]  hi, lo;
  logic          div_zero, op_err;

  alu_seq_n #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .inc_pc(inc_pc), .branch(branch),
    .reg_a(reg_a), .reg_b(reg_b), .out_valid(out_valid),
    .reg_c(reg_c), .hi(hi), .lo(lo),
    .div_zero(div_zero), .op_err(op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [63:0]   c;
    logic [31:0]   h;
    logic [31:0]   l;
    logic          dz;
    logic          err;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          busy_until = 0;
  bit          in_rst = 1'b1;
  logic [63:0] regc_m = '0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Reference result of one accepted op, from the opcode's meaning
  task automatic took();
    exp_t        e;
    logic [31:0] a, b, r;
    int          sa, sb, sh;
    longint      p, qq, rr;
    a = reg_a; b = reg_b; sa = reg_a; sb = reg_b;
    sh = int'(b % 32);
    r = '0;
    e.due = cyc; e.dz = 1'b0; e.err = 1'b0;
    e.c = regc_m;
    if (inc_pc) begin
      e.c = {32'h0, b + 32'd1};
    end else begin
      case (ctrl)
        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: e.c = {32'h0, a + b};
        OP_SUB:  e.c = {32'h0, a - b};
        OP_AND, OP_ANDI: e.c = {32'h0, a & b};
        OP_OR, OP_ORI:   e.c = {32'h0, a | b};
        OP_NOT:  e.c = {32'h0, ~b};
        OP_NEG:  e.c = {32'h0, 32'd0 - b};
        OP_SHL:  e.c = {32'h0, a << sh};
        OP_SHR:  e.c = {32'h0, a >> sh};
        OP_SHRA: e.c = {32'h0, 32'(sa >>> sh)};
        OP_ROL: begin
          r = a;
          repeat (sh) r = {r[30:0], r[31]};
          e.c = {32'h0, r};
        end
        OP_ROR: begin
          r = a;
          repeat (sh) r = {r[0], r[31:1]};
          e.c = {32'h0, r};
        end
        OP_BR:   e.c = {32'h0, branch ? a + b : a};
        OP_MFHI: e.c = {32'h0, hi_m};
        OP_MFLO: e.c = {32'h0, lo_m};
        OP_MUL: begin
          p = longint'(sa) * longint'(sb);
          hi_m = p[63:32]; lo_m = p[31:0];
          e.c = p;
          e.due = cyc + W + 1; busy_until = cyc + W + 1;
        end
        OP_DIV: begin
          if (b == 0) begin
            hi_m = a; lo_m = '1; e.dz = 1'b1;
          end else begin
            qq = longint'(sa) / longint'(sb);
            rr = longint'(sa) % longint'(sb);
            lo_m = qq[31:0]; hi_m = rr[31:0];
            e.due = cyc + W + 1; busy_until = cyc + W + 1;
          end
          e.c = {hi_m, lo_m};
        end
        OP_NOP, OP_HALT, OP_IN, OP_OUT, OP_JR, OP_JAL: e.c = regc_m;
        default: begin e.c = '0; e.err = 1'b1; end
      endcase
    end
    e.h = hi_m; e.l = lo_m;
    regc_m = e.c;
    q.push_back(e);
  endtask

  task automatic put(input logic [4:0] op, input logic inc, input logic br,
                     input logic [31:0] a, input logic [31:0] b);
    ctrl = op; inc_pc = inc; branch = br; reg_a = a; reg_b = b;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [4:0] op, input logic inc, input logic br,
                      input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {63'h0, in_ready}, 64'h1);
    put(op, inc, br, a, b);
    @(posedge clk); #1;
    took();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    q.delete();
    regc_m = '0; hi_m = '0; lo_m = '0;
    busy_until = 0;
    in_rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    #1;
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL idle_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    exp_t e;
    if (!in_rst) begin
      chk("in_ready", {63'h0, in_ready}, {63'h0, cyc >= busy_until});
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("stray_out_valid", 64'h1, 64'h0);
        end else begin
          e = q.pop_front();
          chk("latency", 64'(cyc), 64'(e.due));
          chk("reg_c", reg_c, e.c);
          chk("hi", {32'h0, hi}, {32'h0, e.h});
          chk("lo", {32'h0, lo}, {32'h0, e.l});
          chk("div_zero", {63'h0, div_zero}, {63'h0, e.dz});
          chk("op_err", {63'h0, op_err}, {63'h0, e.err});
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_out_valid", 64'h0, 64'h1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int n, lowcnt;
    do_reset();
    @(negedge clk); #1;
    chk("rst_reg_c", reg_c, 64'h0);
    chk("rst_hi", {32'h0, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_flags", {62'h0, div_zero, op_err}, 64'h0);

    send(OP_ADD, 0, 0, 32'h5, 32'h3);
    @(negedge clk); #1;
    chk("add_valid", {63'h0, out_valid}, 64'h1);
    chk("add_reg_c", reg_c, 64'h8);
    chk("add_ready", {63'h0, in_ready}, 64'h1);

    send(OP_MUL, 0, 0, 32'hFFFF_FFFE, 32'h3);
    n = 1; lowcnt = 0;
    forever begin
      @(negedge clk);
      if (!in_ready) lowcnt++;
      if (out_valid || n > 100) break;
      @(posedge clk);
      n++;
    end
    #1;
    chk("mul_edges_incl_accept", 64'(n), 64'd34);
    chk("mul_ready_low_cycles", 64'(lowcnt), 64'd33);
    chk("mul_hi", {32'h0, hi}, 64'hFFFF_FFFF);
    chk("mul_lo", {32'h0, lo}, 64'hFFFF_FFFA);
    send(OP_MFHI, 0, 0, 32'h0, 32'h0);
    @(negedge clk); #1;
    chk("mfhi", reg_c, 64'h0000_0000_FFFF_FFFF);

    send(OP_DIV, 0, 0, 32'hFFFF_FFF9, 32'h2);
    wait_idle();
    chk("div_lo", {32'h0, lo}, 64'hFFFF_FFFD);
    chk("div_hi", {32'h0, hi}, 64'hFFFF_FFFF);
    send(OP_DIV, 0, 0, 32'h5, 32'h0);
    @(negedge clk); #1;
    chk("div0_latency1", {63'h0, out_valid}, 64'h1);
    chk("div0_lo", {32'h0, lo}, 64'hFFFF_FFFF);
    chk("div0_hi", {32'h0, hi}, 64'h5);
    chk("div0_flag", {63'h0, div_zero}, 64'h1);
    send(OP_NOP, 0, 0, 32'h1, 32'h1);
    @(negedge clk); #1;
    chk("nop_clears_dz", {63'h0, div_zero}, 64'h0);
    chk("nop_keeps_reg_c", reg_c, 64'h0000_0005_FFFF_FFFF);

    send(OP_DIV, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("min_div_lo", {32'h0, lo}, 64'h8000_0000);
    chk("min_div_hi", {32'h0, hi}, 64'h0);

    send(OP_MUL, 0, 0, 32'h1234, 32'h5678);
    repeat (9) @(posedge clk);
    do_reset();
    @(negedge clk); #1;
    chk("abort_ready", {63'h0, in_ready}, 64'h1);
    chk("abort_hilo", {hi, lo}, 64'h0);
    repeat (40) @(negedge clk);

    @(negedge clk);
    put(OP_SHRA, 0, 0, 32'h8000_0000, 32'h0000_0024);
    @(posedge clk); #1;
    took();
    put(OP_ROL, 0, 0, 32'h8000_0001, 32'h1);
    @(negedge clk); #1;
    chk("b2b_valid1", {63'h0, out_valid}, 64'h1);
    chk("b2b_shra", reg_c, 64'hF800_0000);
    @(posedge clk); #1;
    took();
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("b2b_valid2", {63'h0, out_valid}, 64'h1);
    chk("b2b_rol", reg_c, 64'h3);

    send(OP_SUB, 1, 0, 32'h7, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    chk("inc_pc", reg_c, 64'h0);
    send(5'd31, 0, 0, 32'h7, 32'h9);
    @(negedge clk); #1;
    chk("unk_reg_c", reg_c, 64'h0);
    chk("unk_op_err", {63'h0, op_err}, 64'h1);
    send(OP_BR, 0, 0, 32'h100, 32'h20);
    @(negedge clk); #1;
    chk("br_not_taken", reg_c, 64'h100);
    chk("br_clears_err", {63'h0, op_err}, 64'h0);

    send(OP_BR, 0, 1, 32'h100, 32'h20);
    send(OP_ROR, 0, 0, 32'h0000_0003, 32'h0000_0041);
    send(OP_SHL, 0, 0, 32'h0000_00F0, 32'hFFFF_FFE4);
    send(OP_NEG, 0, 0, 32'h0, 32'h0000_0001);
    send(OP_NOT, 0, 0, 32'h0, 32'h0F0F_0000);
    send(OP_AND, 0, 0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    send(OP_MUL, 0, 0, 32'h8000_0000, 32'h8000_0000);
    send(OP_DIV, 0, 0, 32'h0000_0007, 32'hFFFF_FFFE);
    send(OP_MFLO, 0, 0, 32'h0, 32'h0);
    send(OP_JAL, 1, 0, 32'h0, 32'h0000_0FFF);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
